slp_weight_update: RTL
======================

Name: slp_weight_update

Overview:
- Sequential weight-update stage for the single-layer perceptron.
- Consumes the per-sample error produced by the error stage and owns the N-entry weight register file.
- Walks the entries one per cycle through the combinational per-weight delta calculator (slp_calc_weight), writes each new weight back, and reports sticky arithmetic flags plus a done pulse to the training controller.

Parameters:
- N, 4, number of inputs / weights (N >= 1)
- I_CONF, `DEF_DCONF, input data configuration; dtype selects BOOL/INT/FXP for the whole block
- R_CONF, `DEF_DCONF, learning-rate configuration
- W_CONF, `DEF_DCONF, weight configuration
- P_CONF, `DEF_DCONF, error configuration
- I_PREC/R_PREC/W_PREC/P_PREC, derived from *_CONF.prec, not overridden
- NW, N (N+1 with SLP_BIAS_EN), derived, stored weight count

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  update request from error stage
- req_ready  out  1  block can accept a request
- in_vec  in  N*I_PREC  sample inputs; entry i at [i*I_PREC +: I_PREC]
- rate  in  R_PREC  learning rate; ignored for BOOL
- error  in  P_PREC  error for this sample
- ld_en  in  1  direct weight load strobe
- ld_idx  in  $clog2(NW)  load index
- ld_weight  in  W_PREC  load value
- weight_out  out  NW*W_PREC  current weights, registered
- done  out  1  one-cycle pulse, update complete
- udf  out  1  sticky underflow of the last update
- ovf  out  1  sticky overflow of the last update
- rounded  out  1  sticky rounding of the last update

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on port reset.
- Reset: state IDLE, all weights 0, idx 0, done/udf/ovf/rounded 0, req_ready 1 the cycle after reset deasserts. Reset mid-UPDATE aborts: partially updated weights are cleared to 0 with the rest.
- FSM states: IDLE, UPDATE, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready: latch in_vec, rate, error; clear udf/ovf/rounded; idx<=0; go to UPDATE.
- UPDATE: req_ready=0. The calculator is fed in_vec[idx], rate, error, weight[idx]. Each cycle: weight[idx]<=new_weight; flags |= calculator flags; idx++. When idx==NW-1, go to DONE.
- DONE: done=1 for exactly one cycle, flags stable; go to IDLE. req_ready stays 0 in DONE.
- Latency: accept at cycle T, last write at T+NW, done at T+NW+1, next accept possible at T+NW+2.
- Flags hold until the next accepted request. BOOL and INT paths drive udf/rounded 0; BOOL also drives ovf 0 (per calculator).
- Arithmetic, saturation and wrap behaviour are exactly those of slp_calc_weight. This block adds no extra width handling.
- ld_en: honoured only in IDLE; ignored (dropped) in UPDATE/DONE. ld_idx >= NW is ignored.
- ld_en together with request accept in the same IDLE cycle: the load is written, and the update then uses the loaded value.
- req_valid while not ready: no effect. The upstream stage must hold its data; latched copies make later input changes harmless.
- weight_out reflects register contents; mid-update it shows mixed old/new values. Consumers sample on done.

Optional Feature:
- SLP_BIAS_EN defined: NW=N+1. Entry N is a bias weight whose input is the constant one of the I_CONF type (BOOL 1'b1, INT 1, FXP 1.0 at the I_CONF fraction point), updated last. Latency grows by one cycle.
- Undefined: NW=N, no bias entry, no constant-one logic.

Decomposition:
- Shared perceptron package: FSM state enum (SLP_UPD_IDLE/UPDATE/DONE), the constant-one function per dconf_t, and the NW derivation.
- One sub-module: slp_calc_weight instantiated once and time-multiplexed over idx. No other sub-modules.

Test Plan:
- Config: INT, I/R/P 8-bit, W 8-bit, N=4.
- Reset mid-update: assert reset at T+2 -> weights all 0, state IDLE, req_ready=1, no done pulse.
- Basic update: load 10,20,30,40; in=1,2,0,-1, rate=1, error=2 -> weights 12,24,30,38; done exactly at T+5; ovf=0.
- Overflow: weight0=127, in0=1, rate=1, error=1 -> ovf=1 at done; ovf cleared on next accepted request with error=0.
- Load blocking: ld_en during UPDATE with ld_idx=1, value 99 -> ignored, weight1 is the computed value. Same-cycle load+accept in IDLE -> update starts from the loaded value.
- Back-to-back requests with req_valid held high -> second accept exactly at T+6, req_ready low T+1..T+5.
- SLP_BIAS_EN: bias=5, error=3, rate=1 -> bias 8, done at T+6; FXP config sets rounded when the fractional product is truncated.

Source files
------------

// File: rtl/slp_weight_update_pkg.sv
// ---------------------------------------------------------------------------
// slp_weight_update_pkg
//   Shared perceptron definitions used by the weight-update stage:
//     - dtype_t / dconf_t : data-type configuration (BOOL / INT / FXP, width,
//                           fraction bits) carried as a packed parameter.
//     - slp_upd_state_t   : weight-update FSM state encoding.
//     - slp_nw()          : stored-weight count (adds the bias entry when
//                           SLP_BIAS_EN is defined).
//     - slp_one()         : the constant "one" of a given data configuration.
//   Optional feature macro: SLP_BIAS_EN (adds a bias weight, NW = N + 1).
//   Also provides the DEF_DCONF macro (8-bit signed integer) as the default
//   configuration for every *_CONF parameter.
// ---------------------------------------------------------------------------
package slp_weight_update_pkg;

  typedef enum logic [1:0] {
    DT_BOOL = 2'd0,
    DT_INT  = 2'd1,
    DT_FXP  = 2'd2
  } dtype_t;

  // prec = total bit width, frac = fraction bits (meaningful for FXP only)
  typedef struct packed {
    dtype_t     dtype;
    logic [7:0] prec;
    logic [7:0] frac;
  } dconf_t;

  localparam dconf_t DEF_DCONF_VAL = '{dtype: DT_INT, prec: 8'd8, frac: 8'd0};

  typedef enum logic [1:0] {
    SLP_UPD_IDLE   = 2'd0,
    SLP_UPD_UPDATE = 2'd1,
    SLP_UPD_DONE   = 2'd2
  } slp_upd_state_t;

  // Number of stored weights for N inputs.
  function automatic int slp_nw(input int n);
`ifdef SLP_BIAS_EN
    return n + 1;
`else
    return n;
`endif
  endfunction

  // Constant one in the representation of configuration c:
  // BOOL and INT use 1, FXP places 1.0 at the fraction point.
  function automatic logic [63:0] slp_one(input dconf_t c);
    if (c.dtype == DT_FXP) begin
      return 64'd1 << c.frac;
    end
    return 64'd1;
  endfunction

endpackage

`ifndef DEF_DCONF
`define DEF_DCONF slp_weight_update_pkg::DEF_DCONF_VAL
`endif

// File: rtl/slp_weight_update_calc.sv
// ---------------------------------------------------------------------------
// slp_calc_weight
//   Combinational per-weight update: new_weight = weight + in * rate * error.
//   The block-wide data type is taken from I_CONF.dtype.
//     BOOL : the weight LSB toggles when both input and error LSBs are set;
//            rate is ignored, all flags are 0.
//     INT  : full-precision product added to the weight, result saturated to
//            the signed W_PREC range; ovf flags saturation, udf/rounded are 0.
//     FXP  : product aligned from (I+R+P) fraction bits to W fraction bits by
//            an arithmetic shift (truncation toward -inf). rounded = dropped
//            bits were non-zero, udf = non-zero product vanished after
//            alignment, ovf = sum saturated.
//   Ports:
//     in_val     in  I_PREC  input sample entry
//     rate       in  R_PREC  learning rate
//     err        in  P_PREC  sample error
//     weight     in  W_PREC  current weight
//     new_weight out W_PREC  updated weight
//     udf/ovf/rounded out 1  arithmetic flags for this update
// ---------------------------------------------------------------------------
`ifndef DEF_DCONF
`define DEF_DCONF slp_weight_update_pkg::DEF_DCONF_VAL
`endif

module slp_calc_weight
  import slp_weight_update_pkg::*;
#(
  parameter dconf_t I_CONF = `DEF_DCONF,
  parameter dconf_t R_CONF = `DEF_DCONF,
  parameter dconf_t W_CONF = `DEF_DCONF,
  parameter dconf_t P_CONF = `DEF_DCONF,
  localparam int I_PREC = int'(I_CONF.prec),
  localparam int R_PREC = int'(R_CONF.prec),
  localparam int W_PREC = int'(W_CONF.prec),
  localparam int P_PREC = int'(P_CONF.prec)
) (
  input  logic [I_PREC-1:0] in_val,
  input  logic [R_PREC-1:0] rate,
  input  logic [P_PREC-1:0] err,
  input  logic [W_PREC-1:0] weight,
  output logic [W_PREC-1:0] new_weight,
  output logic              udf,
  output logic              ovf,
  output logic              rounded
);

  localparam bit IS_BOOL = (I_CONF.dtype == DT_BOOL);
  localparam bit IS_FXP  = (I_CONF.dtype == DT_FXP);

  // Net fraction shift from the product's fraction point to the weight's.
  localparam int FRAC_SH = IS_FXP ? (int'(I_CONF.frac) + int'(R_CONF.frac) +
                                     int'(P_CONF.frac) - int'(W_CONF.frac)) : 0;
  localparam int RSH = (FRAC_SH > 0) ? FRAC_SH : 0;
  localparam int LSH = (FRAC_SH < 0) ? -FRAC_SH : 0;

  // Product width is exact; the sum width leaves room for the left shift,
  // the weight and one carry so saturation can be detected after the add.
  localparam int PW = I_PREC + R_PREC + P_PREC;
  localparam int SW = PW + W_PREC + LSH + 1;

  localparam logic [SW-1:0]        RMASK = ~({SW{1'b1}} << RSH);
  localparam logic signed [SW-1:0] W_MAX = (SW'(1) << (W_PREC - 1)) - SW'(1);
  localparam logic signed [SW-1:0] W_MIN = ~W_MAX;

  logic signed [PW-1:0] a_s;
  logic signed [PW-1:0] b_s;
  logic signed [PW-1:0] c_s;
  logic signed [PW-1:0] prod_s;
  logic signed [SW-1:0] ext_s;
  logic signed [SW-1:0] aligned_s;
  logic signed [SW-1:0] sum_s;
  logic [W_PREC-1:0]    sat_w;
  logic                 sat_ovf;
  logic                 drop_nz;
  logic                 vanished;

  always_comb begin
    a_s       = PW'($signed(in_val));
    b_s       = PW'($signed(rate));
    c_s       = PW'($signed(err));
    prod_s    = a_s * b_s * c_s;
    ext_s     = SW'(prod_s);
    aligned_s = (ext_s >>> RSH) <<< LSH;
    sum_s     = SW'($signed(weight)) + aligned_s;
    drop_nz   = |(ext_s & RMASK);
    vanished  = (prod_s != '0) && (aligned_s == '0);

    sat_w   = sum_s[W_PREC-1:0];
    sat_ovf = 1'b0;
    if (sum_s > W_MAX) begin
      sat_w   = W_MAX[W_PREC-1:0];
      sat_ovf = 1'b1;
    end else if (sum_s < W_MIN) begin
      sat_w   = W_MIN[W_PREC-1:0];
      sat_ovf = 1'b1;
    end
  end

  always_comb begin
    new_weight = sat_w;
    ovf        = sat_ovf;
    udf        = 1'b0;
    rounded    = 1'b0;
    if (IS_BOOL) begin
      new_weight = weight ^ W_PREC'(in_val[0] & err[0]);
      ovf        = 1'b0;
    end else if (IS_FXP) begin
      udf     = vanished;
      rounded = drop_nz;
    end
  end

endmodule

// File: rtl/slp_weight_update.sv
// ---------------------------------------------------------------------------
// slp_weight_update
//   Sequential weight-update stage of the single-layer perceptron. Owns the
//   NW-entry weight register file and walks it one entry per cycle through a
//   single time-multiplexed slp_calc_weight, writing each result back.
//   Optional feature macro: SLP_BIAS_EN -> one extra bias entry (index N)
//   whose input is the constant one of the I_CONF type, updated last.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     req_valid/req_ready update request handshake (ready only in IDLE)
//     in_vec              N sample inputs, entry i at [i*I_PREC +: I_PREC]
//     rate, error         learning rate and sample error
//     ld_en/ld_idx/ld_weight  direct weight load, honoured in IDLE only
//     weight_out          all weights, entry i at [i*W_PREC +: W_PREC]
//     done                one-cycle pulse after the last write
//     udf/ovf/rounded     sticky flags of the last accepted update
// ---------------------------------------------------------------------------
`ifndef DEF_DCONF
`define DEF_DCONF slp_weight_update_pkg::DEF_DCONF_VAL
`endif

module slp_weight_update
  import slp_weight_update_pkg::*;
#(
  parameter int     N      = 4,
  parameter dconf_t I_CONF = `DEF_DCONF,
  parameter dconf_t R_CONF = `DEF_DCONF,
  parameter dconf_t W_CONF = `DEF_DCONF,
  parameter dconf_t P_CONF = `DEF_DCONF,
  localparam int I_PREC = int'(I_CONF.prec),
  localparam int R_PREC = int'(R_CONF.prec),
  localparam int W_PREC = int'(W_CONF.prec),
  localparam int P_PREC = int'(P_CONF.prec),
  localparam int NW     = slp_nw(N),
  localparam int IDX_W  = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [N*I_PREC-1:0]  in_vec,
  input  logic [R_PREC-1:0]    rate,
  input  logic [P_PREC-1:0]    error,
  input  logic                 ld_en,
  input  logic [IDX_W-1:0]     ld_idx,
  input  logic [W_PREC-1:0]    ld_weight,
  output logic [NW*W_PREC-1:0] weight_out,
  output logic                 done,
  output logic                 udf,
  output logic                 ovf,
  output logic                 rounded
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

  slp_upd_state_t    state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [W_PREC-1:0] weight_q [NW];
  logic [W_PREC-1:0] weight_d [NW];
  logic [I_PREC-1:0] in_q [N];
  logic [I_PREC-1:0] in_d [N];
  logic [R_PREC-1:0] rate_q, rate_d;
  logic [P_PREC-1:0] err_q, err_d;
  logic              udf_q, udf_d;
  logic              ovf_q, ovf_d;
  logic              rnd_q, rnd_d;

  // Calculator operands: latched inputs, plus the constant one for the bias.
  logic [I_PREC-1:0] op_in [NW];
  logic [W_PREC-1:0] calc_weight;
  logic              calc_udf;
  logic              calc_ovf;
  logic              calc_rnd;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_op_in
      assign op_in[gi] = in_q[gi];
    end
  endgenerate

`ifdef SLP_BIAS_EN
  localparam logic [I_PREC-1:0] BIAS_ONE = I_PREC'(slp_one(I_CONF));
  assign op_in[N] = BIAS_ONE;
`endif

  slp_calc_weight #(
    .I_CONF (I_CONF),
    .R_CONF (R_CONF),
    .W_CONF (W_CONF),
    .P_CONF (P_CONF)
  ) u_calc (
    .in_val     (op_in[idx_q]),
    .rate       (rate_q),
    .err        (err_q),
    .weight     (weight_q[idx_q]),
    .new_weight (calc_weight),
    .udf        (calc_udf),
    .ovf        (calc_ovf),
    .rounded    (calc_rnd)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    weight_d = weight_q;
    in_d     = in_q;
    rate_d   = rate_q;
    err_d    = err_q;
    udf_d    = udf_q;
    ovf_d    = ovf_q;
    rnd_d    = rnd_q;

    case (state_q)
      SLP_UPD_IDLE: begin
        // The load is applied before an accept in the same cycle, so the
        // update naturally starts from the loaded value. Indices >= NW never
        // match and are dropped.
        if (ld_en) begin
          for (int i = 0; i < NW; i++) begin
            if (ld_idx == IDX_W'(i)) begin
              weight_d[i] = ld_weight;
            end
          end
        end
        if (req_valid) begin
          for (int i = 0; i < N; i++) begin
            in_d[i] = in_vec[i*I_PREC +: I_PREC];
          end
          rate_d  = rate;
          err_d   = error;
          udf_d   = 1'b0;
          ovf_d   = 1'b0;
          rnd_d   = 1'b0;
          idx_d   = '0;
          state_d = SLP_UPD_UPDATE;
        end
      end

      SLP_UPD_UPDATE: begin
        for (int i = 0; i < NW; i++) begin
          if (idx_q == IDX_W'(i)) begin
            weight_d[i] = calc_weight;
          end
        end
        udf_d = udf_q | calc_udf;
        ovf_d = ovf_q | calc_ovf;
        rnd_d = rnd_q | calc_rnd;
        if (idx_q == LAST_IDX) begin
          state_d = SLP_UPD_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      SLP_UPD_DONE: begin
        idx_d   = '0;
        state_d = SLP_UPD_IDLE;
      end

      default: begin
        state_d = SLP_UPD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SLP_UPD_IDLE;
      idx_q   <= '0;
      for (int i = 0; i < NW; i++) begin
        weight_q[i] <= '0;
      end
      for (int i = 0; i < N; i++) begin
        in_q[i] <= '0;
      end
      rate_q <= '0;
      err_q  <= '0;
      udf_q  <= 1'b0;
      ovf_q  <= 1'b0;
      rnd_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      weight_q <= weight_d;
      in_q     <= in_d;
      rate_q   <= rate_d;
      err_q    <= err_d;
      udf_q    <= udf_d;
      ovf_q    <= ovf_d;
      rnd_q    <= rnd_d;
    end
  end

  generate
    for (gi = 0; gi < NW; gi++) begin : g_wout
      assign weight_out[gi*W_PREC +: W_PREC] = weight_q[gi];
    end
  endgenerate

  assign req_ready = (state_q == SLP_UPD_IDLE);
  assign done      = (state_q == SLP_UPD_DONE);
  assign udf       = udf_q;
  assign ovf       = ovf_q;
  assign rounded   = rnd_q;

endmodule
